// File: rtl/rf_arb_pkg.sv
// Shared sizing, id type and response-state encoding for the register-file read arbiter.
package rf_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 64;
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef logic [ID_W-1:0] req_id_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } rsp_state_t;

endpackage

// File: rtl/rf_read_arbiter_rr_pick.sv
// Round-robin picker: first valid requester at or after ptr, wrapping; combinational.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [IDW-1:0]     ptr,
    input  logic [NUM_REQ-1:0] vld,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDW-1:0]     gnt_idx,
    output logic               gnt_any
);

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        // First pass covers ptr..NUM_REQ-1, second pass wraps to 0..ptr-1.
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!gnt_any && vld[j] && (j >= int'(ptr))) begin
                gnt_any = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = IDW'(j);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!gnt_any && vld[j]) begin
                gnt_any = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/rf_read_arbiter.sv
// Shares one register-file read port among NUM_REQ requesters; grant is combinational,
// response registered one cycle later and held while rsp_ready is low (no grants then).
module rf_read_arbiter #(
    parameter int NUM_REQ = rf_arb_pkg::NUM_REQ,
    parameter int ADDR_W  = rf_arb_pkg::ADDR_W,
    parameter int DATA_W  = rf_arb_pkg::DATA_W,
    localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           rd_en,
    output logic [ADDR_W-1:0]              rd_addr,
    input  logic [DATA_W-1:0]              rd_data,
    output logic                           rsp_valid,
    output logic [IDW-1:0]                 rsp_id,
    output logic [DATA_W-1:0]              rsp_data,
    input  logic                           rsp_ready
);

    import rf_arb_pkg::*;

    rsp_state_t          state_q, state_d;
    logic [IDW-1:0]      ptr_q, ptr_d;
    logic [IDW-1:0]      rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

    logic                port_free;
    logic [NUM_REQ-1:0]  pick_vld;
    logic [NUM_REQ-1:0]  pick_gnt;
    logic [IDW-1:0]      pick_idx;
    logic                pick_any;

    // Gating with reset keeps the read port quiet while reset is held, whatever the inputs.
    always_comb begin
        port_free = (state_q == EMPTY) || rsp_ready;
        pick_vld  = (port_free && !reset) ? req_valid : '0;
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr_pick (
        .ptr     (ptr_q),
        .vld     (pick_vld),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    always_comb begin
        req_ready  = pick_gnt;
        rd_en      = pick_any;
        rd_addr    = pick_any ? req_addr[pick_idx] : '0;

        state_d    = state_q;
        ptr_d      = ptr_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;

        if (pick_any) begin
            ptr_d      = (pick_idx == IDW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
            rsp_id_d   = pick_idx;
            rsp_data_d = rd_data;
        end

        case (state_q)
            EMPTY: begin
                if (pick_any) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (rsp_ready && !pick_any) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= EMPTY;
            ptr_q      <= '0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

endmodule
